instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter MEMORY_DEPTH, default 64, words in Program_Memory; sizes the fetch range check.
REQ-002 Parameter DATA_WIDTH, default 32, width of the address, instruction and PC datapath.
REQ-003 Parameter RESET_PC, default 32'h0040_0000, PC value loaded at reset; base of the text segment.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 Stall_i  input  1  hold the PC and the IF/ID register.
REQ-007 Flush_i  input  1  replace the IF/ID contents with a bubble.
REQ-008 Branch_Taken_i  input  1  redirect the PC to Branch_Target_i.
REQ-009 Branch_Target_i  input  DATA_WIDTH  branch destination byte address.
REQ-010 Jump_i  input  1  J-format redirect.
REQ-011 Jump_Target_i  input  26  J-format instruction index field.
REQ-012 Jr_i  input  1  register-indirect redirect.
REQ-013 Jr_Address_i  input  DATA_WIDTH  register-indirect destination.
REQ-014 Instruction_i  input  DATA_WIDTH  combinational instruction returned by Program_Memory.
REQ-015 Address_o  output  DATA_WIDTH  current PC, drives Program_Memory Address_i.
REQ-016 IF_ID_Instruction_o  output  DATA_WIDTH  registered fetched instruction.
REQ-017 IF_ID_PC_Plus4_o  output  DATA_WIDTH  registered PC+4 of that instruction.
REQ-018 IF_ID_Valid_o  output  1  IF/ID holds a real instruction.
REQ-019 Fetch_Fault_o  output  1  sticky illegal-fetch flag.

Function
REQ-020 Address_o SHALL equal the PC register directly, with no combinational path from any input.
REQ-021 PC_Plus4 SHALL be PC + 4, computed modulo 2^DATA_WIDTH.
REQ-022 Next PC SHALL use this priority: Jr_i -> Jr_Address_i; then Jump_i -> {PC_Plus4[31:28], Jump_Target_i, 2'b00}; then Branch_Taken_i -> Branch_Target_i; then Stall_i -> PC (hold); otherwise PC_Plus4.
REQ-023 A redirect (Jr_i, Jump_i or Branch_Taken_i) SHALL override Stall_i for the PC update in the same cycle.
REQ-024 IF/ID update priority SHALL be: Flush_i -> instruction 32'h0000_0000, PC+4 of 0, valid 0; then Stall_i -> hold; otherwise load {Instruction_i, PC_Plus4} with valid 1.
REQ-025 IF/ID update latency SHALL be one cycle: the instruction at Address_o in cycle N appears on IF_ID_Instruction_o in cycle N+1.
REQ-026 Flush_i and Stall_i asserted together SHALL result in a flush.
REQ-027 The PC SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 without error when range checking is disabled.

Reset
REQ-028 On reset assertion, PC SHALL become RESET_PC immediately, without waiting for a clock edge.
REQ-029 On reset assertion, IF_ID_Instruction_o, IF_ID_PC_Plus4_o and IF_ID_Valid_o SHALL become 0.
REQ-030 On reset assertion, Fetch_Fault_o SHALL become 0.
REQ-031 Reset asserted mid-stall or mid-redirect SHALL discard the pending update.
REQ-032 After reset deasserts, the first rising edge SHALL load the instruction at RESET_PC into IF/ID with valid 1.

Configuration
REQ-033 With macro FETCH_RANGE_CHECK_EN defined, a fetch is illegal when Address_o[1:0] != 0, or Address_o < RESET_PC, or Address_o >= RESET_PC + 4*MEMORY_DEPTH.
REQ-034 With FETCH_RANGE_CHECK_EN defined, an illegal fetch SHALL set Fetch_Fault_o at the next edge, sticky until reset.
REQ-035 With FETCH_RANGE_CHECK_EN defined, an illegal fetch SHALL load a bubble (all zeros, valid 0) into IF/ID instead of Instruction_i.
REQ-036 With FETCH_RANGE_CHECK_EN undefined, Fetch_Fault_o SHALL be tied 0, no check logic SHALL be present, and the port SHALL remain.

Structure
REQ-037 A shared header SHALL hold RESET_PC, NOP_INSTRUCTION (32'h0) and the PC increment constant (4).
REQ-038 The PC SHALL be a sub-module PC_Register: a DATA_WIDTH register with enable and asynchronous reset to a parameter value.
REQ-039 The next-PC mux and the IF/ID register SHALL reside in instruction_fetch_unit.

Verification
REQ-040 Reset release with no other inputs -> Address_o steps 0x400000, 0x400004, 0x400008 on successive cycles; IF_ID_PC_Plus4_o lags by one cycle showing 0x400004.
REQ-041 Branch_Taken_i=1, Branch_Target_i=0x400020, with Stall_i=1, at PC 0x400008 -> next Address_o = 0x400020.
REQ-042 Jr_i=1 (Jr_Address_i=0x400010) and Jump_i=1 (Jump_Target_i=0x100003) in the same cycle -> next Address_o = 0x400010.
REQ-043 Flush_i=1 and Stall_i=1 together -> IF_ID_Instruction_o = 0 and IF_ID_Valid_o = 0 next cycle; PC holds.
REQ-044 With FETCH_RANGE_CHECK_EN defined, Jr_Address_i=0x400100 (MEMORY_DEPTH=64) -> Fetch_Fault_o=1 one cycle later and stays 1 until reset; IF/ID shows a bubble.
REQ-045 reset pulsed asynchronously between edges while PC=0x400014 -> Address_o = 0x400000 immediately, before the next edge.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage constants: text-segment base, bubble encoding, PC step.
// No logic; pure compile-time values.
// Imported by the PC register and the fetch unit top.
package instruction_fetch_unit_pkg;

    // Base of the text segment; the PC lands here on reset.
    localparam logic [31:0] IFU_RESET_PC        = 32'h0040_0000;
    // Encoding loaded into IF/ID for a bubble (flush or illegal fetch).
    localparam logic [31:0] IFU_NOP_INSTRUCTION = 32'h0000_0000;
    // Byte distance between sequential instructions.
    localparam int          IFU_PC_INCREMENT    = 4;

endpackage

// File: rtl/instruction_fetch_unit_pc_register.sv
// PC_Register: DATA_WIDTH program-counter flop with load enable.
// Latency: i_d appears on o_q one clock after an enabled edge.
// Hold: i_en low keeps the current value; reset forces RESET_VALUE immediately.
module PC_Register #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_d,
    output logic [DATA_WIDTH-1:0] o_q
);

    logic [DATA_WIDTH-1:0] r_q;

    // Asynchronous reset to the configured value, otherwise load when enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= RESET_VALUE;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC sequencing with redirects, IF/ID pipeline register; macro FETCH_RANGE_CHECK_EN adds fetch fault checking.
// Latency: instruction at Address_o in cycle N is on IF_ID_* in cycle N+1.
// Stall_i holds PC and IF/ID; a redirect still moves the PC; Flush_i beats Stall_i.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                    MEMORY_DEPTH = 64,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = DATA_WIDTH'(IFU_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall_i,
    input  logic                  Flush_i,
    input  logic                  Branch_Taken_i,
    input  logic [DATA_WIDTH-1:0] Branch_Target_i,
    input  logic                  Jump_i,
    input  logic [25:0]           Jump_Target_i,
    input  logic                  Jr_i,
    input  logic [DATA_WIDTH-1:0] Jr_Address_i,
    input  logic [DATA_WIDTH-1:0] Instruction_i,
    output logic [DATA_WIDTH-1:0] Address_o,
    output logic [DATA_WIDTH-1:0] IF_ID_Instruction_o,
    output logic [DATA_WIDTH-1:0] IF_ID_PC_Plus4_o,
    output logic                  IF_ID_Valid_o,
    output logic                  Fetch_Fault_o
);

    // Reject nonsensical memory sizes at elaboration time.
    if (MEMORY_DEPTH <= 0) begin : g_bad_depth
        $error("MEMORY_DEPTH must be positive");
    end

    logic [DATA_WIDTH-1:0] w_pc;
    logic [DATA_WIDTH-1:0] w_pc_plus4;
    logic [DATA_WIDTH-1:0] w_next_pc;
    logic                  w_redirect;
    logic                  w_pc_en;
    logic                  w_fetch_illegal;

    logic [DATA_WIDTH-1:0] r_ifid_instr;
    logic [DATA_WIDTH-1:0] r_ifid_pc4;
    logic                  r_ifid_vld;

    assign w_pc_plus4 = w_pc + DATA_WIDTH'(IFU_PC_INCREMENT);
    assign w_redirect = Jr_i | Jump_i | Branch_Taken_i;
    // A redirect must move the PC even while the stage is stalled.
    assign w_pc_en    = w_redirect | ~Stall_i;

    // Next-PC selection: Jr, then Jump, then Branch, else sequential.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (Jr_i) begin
            w_next_pc = Jr_Address_i;
        end else if (Jump_i) begin
            w_next_pc = {w_pc_plus4[DATA_WIDTH-1:28], Jump_Target_i, 2'b00};
        end else if (Branch_Taken_i) begin
            w_next_pc = Branch_Target_i;
        end
    end

    PC_Register #(
        .DATA_WIDTH  (DATA_WIDTH),
        .RESET_VALUE (RESET_PC)
    ) u_pc_register (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_pc_en),
        .i_d   (w_next_pc),
        .o_q   (w_pc)
    );

    // Address comes straight from the PC flop so memory sees no input-to-output path.
    assign Address_o = w_pc;

`ifdef FETCH_RANGE_CHECK_EN
    localparam logic [DATA_WIDTH:0] LIMIT_ADDR =
        (DATA_WIDTH+1)'(RESET_PC) + (DATA_WIDTH+1)'(IFU_PC_INCREMENT * MEMORY_DEPTH);

    logic r_fetch_fault;

    // Misaligned or outside [RESET_PC, RESET_PC + 4*MEMORY_DEPTH) is illegal.
    assign w_fetch_illegal = (w_pc[1:0] != 2'b00) ||
                             (w_pc < RESET_PC) ||
                             ({1'b0, w_pc} >= LIMIT_ADDR);

    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_fault <= 1'b0;
        end else if (w_fetch_illegal) begin
            r_fetch_fault <= 1'b1;
        end
    end

    assign Fetch_Fault_o = r_fetch_fault;
`else
    assign w_fetch_illegal = 1'b0;
    assign Fetch_Fault_o   = 1'b0;
`endif

    // IF/ID register: flush beats stall; an illegal fetch loads a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ifid_instr <= '0;
            r_ifid_pc4   <= '0;
            r_ifid_vld   <= 1'b0;
        end else if (Flush_i) begin
            r_ifid_instr <= DATA_WIDTH'(IFU_NOP_INSTRUCTION);
            r_ifid_pc4   <= '0;
            r_ifid_vld   <= 1'b0;
        end else if (!Stall_i) begin
            if (w_fetch_illegal) begin
                r_ifid_instr <= DATA_WIDTH'(IFU_NOP_INSTRUCTION);
                r_ifid_pc4   <= '0;
                r_ifid_vld   <= 1'b0;
            end else begin
                r_ifid_instr <= Instruction_i;
                r_ifid_pc4   <= w_pc_plus4;
                r_ifid_vld   <= 1'b1;
            end
        end
    end

    assign IF_ID_Instruction_o = r_ifid_instr;
    assign IF_ID_PC_Plus4_o    = r_ifid_pc4;
    assign IF_ID_Valid_o       = r_ifid_vld;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized traffic vs a reference model.
// Inputs change and outputs are sampled on the falling clock edge.
// Honours FETCH_RANGE_CHECK_EN to select the expected fault behaviour.
module tb_instruction_fetch_unit;

    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam int          DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Stall_i = 1'b0;
    logic        Flush_i = 1'b0;
    logic        Branch_Taken_i = 1'b0;
    logic [31:0] Branch_Target_i = '0;
    logic        Jump_i = 1'b0;
    logic [25:0] Jump_Target_i = '0;
    logic        Jr_i = 1'b0;
    logic [31:0] Jr_Address_i = '0;
    logic [31:0] Instruction_i;
    logic [31:0] Address_o;
    logic [31:0] IF_ID_Instruction_o;
    logic [31:0] IF_ID_PC_Plus4_o;
    logic        IF_ID_Valid_o;
    logic        Fetch_Fault_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_vld, m_fault;

    instruction_fetch_unit dut (
        .clk                 (clk),
        .reset               (reset),
        .Stall_i             (Stall_i),
        .Flush_i             (Flush_i),
        .Branch_Taken_i      (Branch_Taken_i),
        .Branch_Target_i     (Branch_Target_i),
        .Jump_i              (Jump_i),
        .Jump_Target_i       (Jump_Target_i),
        .Jr_i                (Jr_i),
        .Jr_Address_i        (Jr_Address_i),
        .Instruction_i       (Instruction_i),
        .Address_o           (Address_o),
        .IF_ID_Instruction_o (IF_ID_Instruction_o),
        .IF_ID_PC_Plus4_o    (IF_ID_PC_Plus4_o),
        .IF_ID_Valid_o       (IF_ID_Valid_o),
        .Fetch_Fault_o       (Fetch_Fault_o)
    );

    always #5 clk = ~clk;

    // Program memory contents: a distinct, nonzero-ish word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    assign Instruction_i = mem_word(Address_o);

    function automatic logic illegal_addr(input logic [31:0] a);
`ifdef FETCH_RANGE_CHECK_EN
        return (a % 4 != 0) || (a < BASE) || (a >= BASE + 4 * DEPTH);
`else
        return 1'b0;
`endif
    endfunction

    task automatic clear_inputs();
        Stall_i = 0; Flush_i = 0; Branch_Taken_i = 0; Jump_i = 0; Jr_i = 0;
        Branch_Target_i = '0; Jump_Target_i = '0; Jr_Address_i = '0;
    endtask

    task automatic model_reset();
        m_pc = BASE; m_instr = 0; m_pc4 = 0; m_vld = 0; m_fault = 0;
    endtask

    // Advance one clock: model computes the next state from the current inputs.
    task automatic tick();
        logic [31:0] seq, npc, ni, np4;
        logic        nv, bad;
        seq = m_pc + 4;
        bad = illegal_addr(m_pc);
        if (Jr_i)                npc = Jr_Address_i;
        else if (Jump_i)         npc = {seq[31:28], Jump_Target_i, 2'b00};
        else if (Branch_Taken_i) npc = Branch_Target_i;
        else if (Stall_i)        npc = m_pc;
        else                     npc = seq;
        ni = m_instr; np4 = m_pc4; nv = m_vld;
        if (Flush_i) begin
            ni = 0; np4 = 0; nv = 0;
        end else if (!Stall_i) begin
            if (bad) begin ni = 0; np4 = 0; nv = 0; end
            else     begin ni = mem_word(m_pc); np4 = seq; nv = 1; end
        end
        @(negedge clk);
        m_pc = npc; m_instr = ni; m_pc4 = np4; m_vld = nv; m_fault = m_fault | bad;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1;
        model_reset();
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (Address_o !== BASE) begin
            n_fail++; $display("FAIL reset_pc: got %h want %h", Address_o, BASE);
        end
        n_checks++;
        if ({IF_ID_Instruction_o, IF_ID_PC_Plus4_o, IF_ID_Valid_o, Fetch_Fault_o} !== 66'h0) begin
            n_fail++;
            $display("FAIL reset_ifid: instr=%h pc4=%h vld=%b fault=%b want all 0",
                     IF_ID_Instruction_o, IF_ID_PC_Plus4_o, IF_ID_Valid_o, Fetch_Fault_o);
        end
        tick();
        n_checks++;
        if (IF_ID_Instruction_o !== mem_word(BASE) || IF_ID_Valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL first_fetch: instr=%h vld=%b want %h 1",
                     IF_ID_Instruction_o, IF_ID_Valid_o, mem_word(BASE));
        end
    endtask

    task automatic test_sequential();
        do_reset();
        tick();
        n_checks++;
        if (Address_o !== 32'h0040_0004 || IF_ID_PC_Plus4_o !== 32'h0040_0004) begin
            n_fail++;
            $display("FAIL seq_step1: addr=%h pc4=%h want 00400004 00400004", Address_o, IF_ID_PC_Plus4_o);
        end
        tick();
        n_checks++;
        if (Address_o !== 32'h0040_0008 || IF_ID_PC_Plus4_o !== 32'h0040_0008) begin
            n_fail++;
            $display("FAIL seq_step2: addr=%h pc4=%h want 00400008 00400008", Address_o, IF_ID_PC_Plus4_o);
        end
    endtask

    task automatic test_branch_over_stall();
        do_reset();
        tick(); tick();
        Branch_Taken_i = 1; Branch_Target_i = 32'h0040_0020; Stall_i = 1;
        tick();
        clear_inputs();
        n_checks++;
        if (Address_o !== 32'h0040_0020) begin
            n_fail++; $display("FAIL branch_stall_pc: got %h want 00400020", Address_o);
        end
        n_checks++;
        if (IF_ID_PC_Plus4_o !== 32'h0040_0008 || IF_ID_Valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL branch_stall_hold: pc4=%h vld=%b want 00400008 1", IF_ID_PC_Plus4_o, IF_ID_Valid_o);
        end
    endtask

    task automatic test_jr_over_jump();
        do_reset();
        Jr_i = 1; Jr_Address_i = 32'h0040_0010; Jump_i = 1; Jump_Target_i = 26'h010_0003;
        tick();
        clear_inputs();
        n_checks++;
        if (Address_o !== 32'h0040_0010) begin
            n_fail++; $display("FAIL jr_over_jump: got %h want 00400010", Address_o);
        end
        Jump_i = 1; Jump_Target_i = 26'h010_0003; Branch_Taken_i = 1; Branch_Target_i = 32'h0040_0030;
        tick();
        clear_inputs();
        n_checks++;
        if (Address_o !== 32'h0040_000C) begin
            n_fail++; $display("FAIL jump_over_branch: got %h want 0040000c", Address_o);
        end
    endtask

    task automatic test_flush_stall();
        do_reset();
        tick(); tick();
        Stall_i = 1;
        tick();
        n_checks++;
        if (Address_o !== 32'h0040_0008 || IF_ID_PC_Plus4_o !== 32'h0040_0008 || IF_ID_Valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold: addr=%h pc4=%h vld=%b want 00400008 00400008 1",
                     Address_o, IF_ID_PC_Plus4_o, IF_ID_Valid_o);
        end
        Flush_i = 1;
        tick();
        clear_inputs();
        n_checks++;
        if (Address_o !== 32'h0040_0008 || IF_ID_Instruction_o !== 32'h0 ||
            IF_ID_PC_Plus4_o !== 32'h0 || IF_ID_Valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stall: addr=%h instr=%h pc4=%h vld=%b want 00400008 0 0 0",
                     Address_o, IF_ID_Instruction_o, IF_ID_PC_Plus4_o, IF_ID_Valid_o);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        Jr_i = 1; Jr_Address_i = 32'hFFFF_FFFC;
        tick();
        clear_inputs();
        n_checks++;
        if (Address_o !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_load: got %h want fffffffc", Address_o);
        end
        tick();
        n_checks++;
        if (Address_o !== 32'h0 || IF_ID_PC_Plus4_o !== 32'h0 ||
            IF_ID_Instruction_o !== mem_word(32'hFFFF_FFFC) || IF_ID_Valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap: addr=%h pc4=%h instr=%h vld=%b want 0 0 %h 1",
                     Address_o, IF_ID_PC_Plus4_o, IF_ID_Instruction_o, IF_ID_Valid_o,
                     mem_word(32'hFFFF_FFFC));
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (5) tick();
        n_checks++;
        if (Address_o !== 32'h0040_0014) begin
            n_fail++; $display("FAIL pre_async_pc: got %h want 00400014", Address_o);
        end
        Branch_Taken_i = 1; Branch_Target_i = 32'h0040_0030; Stall_i = 1;
        #2;
        reset = 1;
        clear_inputs();
        model_reset();
        #1;
        n_checks++;
        if (Address_o !== BASE || IF_ID_Valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: addr=%h vld=%b want 00400000 0", Address_o, IF_ID_Valid_o);
        end
        #1;
        reset = 0;
        tick();
        n_checks++;
        if (Address_o !== 32'h0040_0004 || IF_ID_Instruction_o !== mem_word(BASE) || IF_ID_Valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL after_async_reset: addr=%h instr=%h vld=%b want 00400004 %h 1",
                     Address_o, IF_ID_Instruction_o, IF_ID_Valid_o, mem_word(BASE));
        end
    endtask

`ifdef FETCH_RANGE_CHECK_EN
    task automatic test_range_check();
        do_reset();
        Jr_i = 1; Jr_Address_i = 32'h0040_00FC;
        tick();
        clear_inputs();
        tick();
        n_checks++;
        if (Address_o !== 32'h0040_0100 || Fetch_Fault_o !== 1'b0 || IF_ID_Valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL last_legal: addr=%h fault=%b vld=%b want 00400100 0 1",
                     Address_o, Fetch_Fault_o, IF_ID_Valid_o);
        end
        Jr_i = 1; Jr_Address_i = BASE;
        tick();
        clear_inputs();
        n_checks++;
        if (Fetch_Fault_o !== 1'b1 || IF_ID_Instruction_o !== 32'h0 || IF_ID_Valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL range_fault: fault=%b instr=%h vld=%b want 1 0 0",
                     Fetch_Fault_o, IF_ID_Instruction_o, IF_ID_Valid_o);
        end
        tick(); tick();
        n_checks++;
        if (Fetch_Fault_o !== 1'b1 || IF_ID_Valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_sticky: fault=%b vld=%b want 1 1", Fetch_Fault_o, IF_ID_Valid_o);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            Stall_i        = ($urandom_range(0, 3) == 0);
            Flush_i        = ($urandom_range(0, 7) == 0);
            Branch_Taken_i = ($urandom_range(0, 7) == 0);
            Jump_i         = ($urandom_range(0, 11) == 0);
            Jr_i           = ($urandom_range(0, 11) == 0);
            Branch_Target_i = BASE + 4 * $urandom_range(0, DEPTH - 1);
            Jr_Address_i    = ($urandom_range(0, 15) == 0) ? $urandom() : BASE + 4 * $urandom_range(0, DEPTH - 1);
            Jump_Target_i   = ($urandom_range(0, 1) == 0) ? 26'($urandom()) : 26'h010_0000 + 26'($urandom_range(0, DEPTH - 1));
            tick();
            n_checks++;
            if (Address_o !== m_pc) begin
                n_fail++; $display("FAIL rand_pc[%0d]: got %h want %h", i, Address_o, m_pc);
            end
            n_checks++;
            if (IF_ID_Instruction_o !== m_instr || IF_ID_PC_Plus4_o !== m_pc4 ||
                IF_ID_Valid_o !== m_vld || Fetch_Fault_o !== m_fault) begin
                n_fail++;
                $display("FAIL rand_ifid[%0d]: got %h %h %b %b want %h %h %b %b", i,
                         IF_ID_Instruction_o, IF_ID_PC_Plus4_o, IF_ID_Valid_o, Fetch_Fault_o,
                         m_instr, m_pc4, m_vld, m_fault);
            end
        end
        clear_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sequential();
        test_branch_over_stall();
        test_jr_over_jump();
        test_flush_stall();
`ifdef FETCH_RANGE_CHECK_EN
        test_range_check();
`else
        test_wrap();
`endif
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
